// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the HI/LO pair: shared shift-add / restoring-divide
// loop with fixed latency, pipeline stall generation and single-cycle HI/LO write strobes.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  hilo_read_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  hi_write_o,
    output logic                  lo_write_o,
    output logic [DATA_WIDTH-1:0] hi_result_o,
    output logic [DATA_WIDTH-1:0] lo_result_o
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StPrep, StRun, StFixup, StDone} state_e;

    state_e          state_q;
    logic            busy_q;
    logic            done_q;
    logic [CntW-1:0] cnt_q;
    logic [2*W-1:0]  acc_q;
    logic            is_div_q;
    logic            is_signed_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic [W-1:0]    mag_a_q;
    logic [W-1:0]    mag_b_q;
    logic [W-1:0]    a_raw_q;
    logic            b_zero_q;
    logic            div_ovf_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    // op[1] selects divide, op[0] selects unsigned.
    logic         op_signed;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;

    always_comb begin
        op_signed = ~op_i[0];
        abs_a     = (op_signed & operand_a_i[W-1]) ? -operand_a_i : operand_a_i;
        abs_b     = (op_signed & operand_b_i[W-1]) ? -operand_b_i : operand_b_i;
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_rem_sh;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [2*W-1:0] div_next;

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right with
    // the carry. Divide: shift left one bit, keep the trial difference when it is non-negative.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
        mul_next   = {mul_sum, acc_q[W-1:1]};
        div_rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
        div_trial  = div_rem_sh - {1'b0, mag_b_q};
        div_ge     = (div_rem_sh >= {1'b0, mag_b_q});
        div_next   = div_ge ? {div_trial[W-1:0], acc_q[W-2:0], 1'b1}
                            : {div_rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   hi_fix;
    logic [W-1:0]   lo_fix;

    always_comb begin
        prod_fix = (is_signed_q & (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
        quot_fix = (is_signed_q & (sign_a_q ^ sign_b_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = (is_signed_q & sign_a_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        hi_fix   = prod_fix[2*W-1:W];
        lo_fix   = prod_fix[W-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                hi_fix = a_raw_q;
                lo_fix = {W{1'b1}};
            end else if (is_signed_q & div_ovf_q) begin
                hi_fix = '0;
                lo_fix = MinNeg;
            end else begin
                hi_fix = rem_fix;
                lo_fix = quot_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            a_raw_q     <= '0;
            b_zero_q    <= 1'b0;
            div_ovf_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            is_div_q    <= op_i[1];
                            is_signed_q <= op_signed;
                            sign_a_q    <= op_signed & operand_a_i[W-1];
                            sign_b_q    <= op_signed & operand_b_i[W-1];
                            mag_a_q     <= abs_a;
                            mag_b_q     <= abs_b;
                            a_raw_q     <= operand_a_i;
                            b_zero_q    <= (operand_b_i == '0);
                            div_ovf_q   <= (operand_a_i == MinNeg) && (operand_b_i == {W{1'b1}});
                            busy_q      <= 1'b1;
                            state_q     <= StPrep;
                        end
                    end
                    StPrep: begin
                        cnt_q   <= CntW'(W - 1);
                        acc_q   <= {{W{1'b0}}, (is_div_q ? mag_a_q : mag_b_q)};
                        state_q <= StRun;
                    end
                    StRun: begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == '0) begin
                            state_q <= StFixup;
                        end
                    end
                    StFixup: begin
                        hi_q    <= hi_fix;
                        lo_q    <= lo_fix;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // A flush arriving in DONE must still suppress the write strobes.
    always_comb begin
        busy_o      = busy_q;
        stall_o     = busy_q & (hilo_read_i | start_i);
        done_o      = done_q & ~abort_i;
        hi_write_o  = done_o;
        lo_write_o  = done_o;
        hi_result_o = hi_q;
        lo_result_o = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer, checked against an arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_read;
    logic        abort;
    logic        busy;
    logic        stall;
    logic        done;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .op_i        (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .hilo_read_i (hilo_read),
        .abort_i     (abort),
        .busy_o      (busy),
        .stall_o     (stall),
        .done_o      (done),
        .hi_write_o  (hi_write),
        .lo_write_o  (lo_write),
        .hi_result_o (hi_res),
        .lo_result_o (lo_res)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Returns {hi, lo} straight from the instruction semantics.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: res = 64'(sx * sy);
            2'd1: res = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else            res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int dc;
        dc = -1;
        tick();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        settle();
        check_eq({tag, "_stall_idle"}, 64'(stall), 64'd0);
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            tick();
            start = 1'b0;
            settle();
            if (c == 1) check_eq({tag, "_busy_c1"}, 64'(busy), 64'd1);
            if (done) dc = c;
        end
        check_eq({tag, "_done_cycle"}, 64'(dc), 64'd35);
        if (dc > 0) begin
            check_eq({tag, "_hi"}, 64'(hi_res), 64'(exp[63:32]));
            check_eq({tag, "_lo"}, 64'(lo_res), 64'(exp[31:0]));
            check_eq({tag, "_wr"}, {62'd0, hi_write, lo_write}, 64'd3);
            tick();
            settle();
            check_eq({tag, "_busy_after"}, {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen;
        int          dc;

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; hilo_read = 1'b0; abort = 1'b0;
        repeat (3) tick();
        hilo_read = 1'b1;
        settle();
        check_eq("reset_outputs", {busy, stall, done, hi_write, lo_write, hi_res, lo_res},
                 '0);
        rst = 1'b0;
        hilo_read = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 2'd3, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF);
        run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div_zero",  2'd2, 32'hFFFF_FFF0, 32'd0,         64'hFFFF_FFF0_FFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = -32'($urandom_range(1, 100));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
        end

        // Abort mid-run, then a fresh op must complete 35 cycles after its own start.
        seen = 1'b0;
        tick();
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            abort = (c == 10);
            settle();
            if (done | hi_write | lo_write) seen = 1'b1;
        end
        tick();
        abort = 1'b0;
        settle();
        check_eq("abort_busy_c11", 64'(busy), 64'd0);
        check_eq("abort_no_strobe", 64'(seen), 64'd0);
        start = 1'b1; op = 2'd1; a = 32'd123456; b = 32'd789;
        dc = -1;
        for (int c = 12; c <= 60 && dc < 0; c++) begin
            tick();
            start = 1'b0;
            settle();
            if (done) dc = c;
        end
        check_eq("abort_restart_done_cycle", 64'(dc), 64'd46);
        check_eq("abort_restart_result", {hi_res, lo_res}, 64'd123456 * 64'd789);
        tick();

        // Abort in DONE wins over the strobes.
        tick();
        start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
        for (int c = 1; c <= 35; c++) begin
            tick();
            start = 1'b0;
            abort = (c == 35);
        end
        settle();
        check_eq("abort_in_done", {61'd0, done, hi_write, lo_write}, 64'd0);
        tick();
        abort = 1'b0;
        settle();
        check_eq("abort_in_done_idle", 64'(busy), 64'd0);

        // abort & start together in IDLE: start ignored.
        start = 1'b1; abort = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        settle();
        check_eq("abort_start_idle", 64'(busy), 64'd0);

        // Hazards: hilo reads and a second start while busy.
        tick();
        start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
        for (int c = 1; c <= 37; c++) begin
            tick();
            start     = 1'b0;
            hilo_read = (c == 5 || c == 35 || c == 36);
            if (c == 20) begin
                start = 1'b1; op = 2'd1; a = 32'hFFFF; b = 32'hFFFF;
            end
            settle();
            if (c == 5)  check_eq("stall_hilo_c5", 64'(stall), 64'd1);
            if (c == 20) check_eq("stall_start_c20", 64'(stall), 64'd1);
            if (c == 35) begin
                check_eq("stall_hilo_c35", 64'(stall), 64'd1);
                check_eq("hazard_done_c35", 64'(done), 64'd1);
                check_eq("hazard_result", {hi_res, lo_res}, {32'd6, 32'd142});
            end
            if (c == 36) check_eq("stall_hilo_idle", {62'd0, stall, busy}, 64'd0);
            if (c == 37) check_eq("hazard_no_queue", 64'(busy), 64'd0);
        end
        hilo_read = 1'b0;

        // Synchronous reset mid-operation.
        tick();
        start = 1'b1; op = 2'd1; a = 32'd77; b = 32'd88;
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start     = 1'b0;
            rst       = (c == 12);
            hilo_read = (c == 13);
            settle();
            if (c == 13) begin
                check_eq("rst_mid_outputs",
                         {busy, stall, done, hi_write, lo_write, hi_res, lo_res}, '0);
            end
            if (c > 13 && done) seen = 1'b1;
        end
        hilo_read = 1'b0;
        check_eq("rst_mid_no_done", 64'(seen), 64'd0);

        run_op("post_rst_mult", 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
